avalon_uart_regs_slave: RTL and testbench

Avalon-MM responder that terminates the UART bridge master's transactions in a four-word register bank shared with the RISC-V core. The master writes received UART words to 0x0/0x4/0x8 and reads the word to transmit from 0xC. The core side sees the stored words with a write strobe, and loads the TX word through a valid/ready-style handshake. The block stalls every access with a programmable number of wait states using a small state machine.

---
 rtl/avalon_uart_regs_slave_if.sv | 21 ++
 rtl/avalon_uart_regs_slave.sv | 147 ++++++++++++++
 tb/tb_avalon_uart_regs_slave.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_uart_regs_slave_if.sv
// Avalon-MM bus bundle between the UART bridge master and the register-bank responder.
interface avalon_uart_regs_slave_if;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic        READ;
    logic        WRITE;
    logic        BEGINTRANSFER;
    logic        LOCK;
    logic [31:0] READDATA;
    logic        WAITREQUEST;

    modport master (
        output ADDRESS, WRITEDATA, READ, WRITE, BEGINTRANSFER, LOCK,
        input  READDATA, WAITREQUEST
    );

    modport slave (
        input  ADDRESS, WRITEDATA, READ, WRITE, BEGINTRANSFER, LOCK,
        output READDATA, WAITREQUEST
    );
endinterface

// File: rtl/avalon_uart_regs_slave.sv
// Avalon-MM responder holding the four-word UART/core register bank, with a
// programmable wait-state FSM and a valid/ready TX word loaded by the core.
module avalon_uart_regs_slave #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    avalon_uart_regs_slave_if.slave        bus,
    output logic [31:0]                    reg_instr,
    output logic [31:0]                    reg_data,
    output logic [31:0]                    reg_ctrl,
    output logic                           wr_strobe,
    output logic [1:0]                     wr_index,
    input  logic [31:0]                    tx_word,
    input  logic                           tx_load,
    output logic                           tx_ready,
    output logic                           tx_full
);

    localparam int unsigned CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          latch;

    logic          mapped_q, rnw_q;
    logic [1:0]    idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   tx_reg;

    logic          req, dec_mapped;
    logic          src_mapped, src_rnw;
    logic [1:0]    src_idx;
    logic [31:0]   rd_val;
    logic          ack_write, ack_tx_read;

    assign req        = bus.BEGINTRANSFER & (bus.READ | bus.WRITE);
    assign dec_mapped = (bus.ADDRESS[31:4] == '0) && (bus.ADDRESS[1:0] == '0);
    assign tx_ready   = RST & ~tx_full & ~bus.LOCK;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    latch    = 1'b1;
                    cnt_nx   = CW'(WAIT_CYCLES);
                    state_nx = (WAIT_CYCLES != 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!bus.READ && !bus.WRITE)
                    state_nx = S_IDLE;
                else if (cnt <= CW'(1))
                    state_nx = S_ACK;
                else
                    cnt_nx = cnt - CW'(1);
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // READDATA is registered into the ACK cycle, so with zero wait states the
    // decode must come straight from the bus rather than the latched request.
    always_comb begin
        src_mapped = (state == S_IDLE) ? dec_mapped : mapped_q;
        src_idx    = (state == S_IDLE) ? bus.ADDRESS[3:2] : idx_q;
        src_rnw    = (state == S_IDLE) ? bus.READ : rnw_q;
        rd_val     = '0;
        if (src_mapped) begin
            case (src_idx)
                2'd0:    rd_val = reg_instr;
                2'd1:    rd_val = reg_data;
                2'd2:    rd_val = reg_ctrl;
                default: rd_val = tx_reg;
            endcase
        end
    end

    assign ack_write   = (state == S_ACK) && !rnw_q && mapped_q && (idx_q != 2'd3);
    assign ack_tx_read = (state == S_ACK) && rnw_q && mapped_q && (idx_q == 2'd3);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bus.WAITREQUEST <= 1'b1;
            bus.READDATA    <= '0;
            mapped_q        <= 1'b0;
            rnw_q           <= 1'b0;
            idx_q           <= '0;
            wdata_q         <= '0;
            reg_instr       <= '0;
            reg_data        <= '0;
            reg_ctrl        <= '0;
            tx_reg          <= '0;
            tx_full         <= 1'b0;
            wr_strobe       <= 1'b0;
            wr_index        <= '0;
        end else begin
            bus.WAITREQUEST <= (state_nx != S_ACK);
            wr_strobe       <= 1'b0;
            if (latch) begin
                mapped_q <= dec_mapped;
                idx_q    <= bus.ADDRESS[3:2];
                rnw_q    <= bus.READ;
                wdata_q  <= bus.WRITEDATA;
            end
            if (state_nx == S_ACK && src_rnw)
                bus.READDATA <= rd_val;
            if (ack_write) begin
                case (idx_q)
                    2'd0:    reg_instr <= wdata_q;
                    2'd1:    reg_data  <= wdata_q;
                    default: reg_ctrl  <= wdata_q;
                endcase
                wr_strobe <= 1'b1;
                wr_index  <= idx_q;
            end
            // An accepted load on the same edge as a TX read wins, keeping tx_full set.
            if (ack_tx_read)
                tx_full <= 1'b0;
            if (tx_load && tx_ready) begin
                tx_reg  <= tx_word;
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_uart_regs_slave.sv
// Directed bench for avalon_uart_regs_slave: one wait-state instance plus a zero-wait instance.
module tb_avalon_uart_regs_slave;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    avalon_uart_regs_slave_if b1 ();
    avalon_uart_regs_slave_if b0 ();

    logic [31:0] instr1, data1, ctrl1, instr0, data0, ctrl0;
    logic        strobe1, strobe0, ready1, ready0, full1, full0;
    logic [1:0]  index1, index0;
    logic [31:0] tx_word1 = '0;
    logic [31:0] tx_word0 = '0;
    logic        tx_load1 = 1'b0;
    logic        tx_load0 = 1'b0;

    avalon_uart_regs_slave #(.WAIT_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .bus(b1.slave),
        .reg_instr(instr1), .reg_data(data1), .reg_ctrl(ctrl1),
        .wr_strobe(strobe1), .wr_index(index1),
        .tx_word(tx_word1), .tx_load(tx_load1), .tx_ready(ready1), .tx_full(full1)
    );

    avalon_uart_regs_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .bus(b0.slave),
        .reg_instr(instr0), .reg_data(data0), .reg_ctrl(ctrl0),
        .wr_strobe(strobe0), .wr_index(index0),
        .tx_word(tx_word0), .tx_load(tx_load0), .tx_ready(ready0), .tx_full(full0)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Runs one transfer on the WAIT_CYCLES=1 instance; returns in the cycle after ACK.
    task automatic do_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output int ack, output int ack_at);
        b1.ADDRESS = addr; b1.WRITEDATA = wd;
        b1.READ = rd; b1.WRITE = ~rd; b1.BEGINTRANSFER = 1'b1;
        ack = -1; ack_at = -1; rdata = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            b1.BEGINTRANSFER = 1'b0;
            if (b1.WAITREQUEST === 1'b0) begin
                ack = c; ack_at = cyc; rdata = b1.READDATA;
                break;
            end
        end
        @(posedge CLK); #1;
        b1.READ = 1'b0; b1.WRITE = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_tx_ready_held: got %b want 0", ready1); end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++; if (b1.WAITREQUEST !== 1'b1) begin errors++; $display("FAIL reset_waitreq: got %b want 1", b1.WAITREQUEST); end
        checks++; if (b1.READDATA !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", b1.READDATA); end
        checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", full1); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", ready1); end
        checks++; if ({strobe1, index1, instr1, data1, ctrl1} !== '0) begin errors++; $display("FAIL reset_regs: got nonzero strobe/index/regs"); end
    endtask

    task automatic test_write_wait1;
        logic [31:0] rd; int ack, at;
        logic [31:0] addrs [3] = '{32'h4, 32'h0, 32'h8};
        logic [31:0] vals  [3] = '{32'h12345678, 32'h11111111, 32'h33333333};
        logic [1:0]  idxs  [3] = '{2'd1, 2'd0, 2'd2};
        for (int i = 0; i < 3; i++) begin
            do_xfer(1'b0, addrs[i], vals[i], rd, ack, at);
            checks++; if (ack !== 2) begin errors++; $display("FAIL write_ack_cycle[%0d]: got %0d want 2", i, ack); end
            checks++; if (strobe1 !== 1'b1 || index1 !== idxs[i]) begin errors++; $display("FAIL write_strobe[%0d]: got %b/%0d want 1/%0d", i, strobe1, index1, idxs[i]); end
            checks++; if (b1.WAITREQUEST !== 1'b1) begin errors++; $display("FAIL write_waitreq_after[%0d]: got %b want 1", i, b1.WAITREQUEST); end
            @(posedge CLK); #1;
            checks++; if (strobe1 !== 1'b0) begin errors++; $display("FAIL write_strobe_width[%0d]: got %b want 0", i, strobe1); end
        end
        checks++; if (data1 !== 32'h12345678) begin errors++; $display("FAIL reg_data: got %h want 12345678", data1); end
        checks++; if (instr1 !== 32'h11111111) begin errors++; $display("FAIL reg_instr: got %h want 11111111", instr1); end
        checks++; if (ctrl1 !== 32'h33333333) begin errors++; $display("FAIL reg_ctrl: got %h want 33333333", ctrl1); end
        for (int i = 0; i < 3; i++) begin
            do_xfer(1'b1, addrs[i], 32'h0, rd, ack, at);
            checks++; if (rd !== vals[i] || ack !== 2) begin errors++; $display("FAIL readback[%0d]: got %h@%0d want %h@2", i, rd, ack, vals[i]); end
        end
    endtask

    task automatic test_zero_wait;
        int ack = -1;
        b0.ADDRESS = 32'h0; b0.WRITEDATA = 32'hDEADBEEF;
        b0.WRITE = 1'b1; b0.READ = 1'b0; b0.BEGINTRANSFER = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK); #1;
            b0.BEGINTRANSFER = 1'b0;
            if (b0.WAITREQUEST === 1'b0) begin ack = c; break; end
        end
        @(posedge CLK); #1;
        b0.WRITE = 1'b0;
        checks++; if (ack !== 1) begin errors++; $display("FAIL zw_ack_cycle: got %0d want 1", ack); end
        checks++; if (strobe0 !== 1'b1 || index0 !== 2'd0) begin errors++; $display("FAIL zw_strobe: got %b/%0d want 1/0", strobe0, index0); end
        checks++; if (instr0 !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_reg_instr: got %h want deadbeef", instr0); end
    endtask

    task automatic test_tx;
        logic [31:0] rd; int ack, at;
        tx_word1 = 32'hCAFEF00D; tx_load1 = 1'b1;
        @(posedge CLK); #1;
        tx_load1 = 1'b0;
        checks++; if (full1 !== 1'b1 || ready1 !== 1'b0) begin errors++; $display("FAIL tx_load_full: got full=%b ready=%b want 1/0", full1, ready1); end
        tx_word1 = 32'h0BADBEEF; tx_load1 = 1'b1;
        @(posedge CLK); #1;
        tx_load1 = 1'b0;
        do_xfer(1'b1, 32'hC, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'hCAFEF00D || ack !== 2) begin errors++; $display("FAIL tx_read: got %h@%0d want cafef00d@2", rd, ack); end
        checks++; if (full1 !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL tx_clear: got full=%b ready=%b want 0/1", full1, ready1); end
    endtask

    task automatic test_lock;
        logic [31:0] rd; int ack, at;
        b1.LOCK = 1'b1; tx_word1 = 32'h11223344; tx_load1 = 1'b1;
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL lock_ready: got %b want 0", ready1); end
        @(posedge CLK); #1;
        checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL lock_no_load: got %b want 0", full1); end
        b1.LOCK = 1'b0;
        #1;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL unlock_ready: got %b want 1", ready1); end
        @(posedge CLK); #1;
        tx_load1 = 1'b0;
        checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL unlock_load: got %b want 1", full1); end
        do_xfer(1'b1, 32'hC, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL unlock_read: got %h want 11223344", rd); end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd; int ack, at;
        do_xfer(1'b1, 32'h10, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'h0 || ack !== 2) begin errors++; $display("FAIL unmapped_read_10: got %h@%0d want 0@2", rd, ack); end
        do_xfer(1'b1, 32'h2, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read_2: got %h want 0", rd); end
        do_xfer(1'b0, 32'hC, 32'hFFFFFFFF, rd, ack, at);
        checks++; if (strobe1 !== 1'b0) begin errors++; $display("FAIL txreg_write_strobe: got %b want 0", strobe1); end
        do_xfer(1'b0, 32'h14, 32'h00000099, rd, ack, at);
        checks++; if (strobe1 !== 1'b0 || data1 !== 32'h12345678) begin errors++; $display("FAIL unmapped_write: got strobe=%b data=%h want 0/12345678", strobe1, data1); end
        do_xfer(1'b1, 32'hC, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'h11223344 || full1 !== 1'b0) begin errors++; $display("FAIL txreg_unchanged: got %h full=%b want 11223344/0", rd, full1); end
    endtask

    task automatic test_abort;
        b1.ADDRESS = 32'h8; b1.WRITEDATA = 32'h77; b1.WRITE = 1'b1; b1.BEGINTRANSFER = 1'b1;
        @(posedge CLK); #1;
        b1.BEGINTRANSFER = 1'b0; b1.WRITE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checks++; if (b1.WAITREQUEST !== 1'b1 || strobe1 !== 1'b0) begin errors++; $display("FAIL abort[%0d]: got wr=%b strobe=%b want 1/0", c, b1.WAITREQUEST, strobe1); end
        end
        checks++; if (ctrl1 !== 32'h33333333) begin errors++; $display("FAIL abort_reg_ctrl: got %h want 33333333", ctrl1); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int ack, at;
        b1.ADDRESS = 32'h0; b1.WRITEDATA = 32'hFFFF0000; b1.WRITE = 1'b1; b1.BEGINTRANSFER = 1'b1;
        @(posedge CLK); #1;
        b1.BEGINTRANSFER = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;
        b1.WRITE = 1'b0; RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checks++; if (b1.WAITREQUEST !== 1'b1 || strobe1 !== 1'b0 || instr1 !== 32'h0) begin errors++; $display("FAIL reset_mid[%0d]: got wr=%b strobe=%b instr=%h want 1/0/0", c, b1.WAITREQUEST, strobe1, instr1); end
        end
        do_xfer(1'b1, 32'h0, 32'h0, rd, ack, at);
        checks++; if (ack !== 2 || rd !== 32'h0) begin errors++; $display("FAIL reset_mid_idle: got %h@%0d want 0@2", rd, ack); end
    endtask

    task automatic test_same_cycle;
        logic [31:0] rd; int ack, at;
        tx_word1 = 32'hAAAA0001; tx_load1 = 1'b1;
        @(posedge CLK); #1;
        tx_load1 = 1'b0;
        do_xfer(1'b1, 32'hC, 32'h0, rd, ack, at);
        b1.ADDRESS = 32'hC; b1.READ = 1'b1; b1.BEGINTRANSFER = 1'b1;
        @(posedge CLK); #1;
        b1.BEGINTRANSFER = 1'b0;
        @(posedge CLK); #1;
        checks++; if (b1.WAITREQUEST !== 1'b0 || b1.READDATA !== 32'hAAAA0001) begin errors++; $display("FAIL same_old_value: got wr=%b %h want 0/aaaa0001", b1.WAITREQUEST, b1.READDATA); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL same_ready: got %b want 1", ready1); end
        tx_word1 = 32'h5555AAAA; tx_load1 = 1'b1;
        @(posedge CLK); #1;
        tx_load1 = 1'b0; b1.READ = 1'b0;
        checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL same_full: got %b want 1", full1); end
        do_xfer(1'b1, 32'hC, 32'h0, rd, ack, at);
        checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL same_new_word: got %h want 5555aaaa", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; int ack, at_a, at_b;
        do_xfer(1'b1, 32'h4, 32'h0, rd, ack, at_a);
        do_xfer(1'b1, 32'h8, 32'h0, rd, ack, at_b);
        checks++; if (at_a < 0 || at_b - at_a !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", at_b - at_a); end
    endtask

    initial begin
        b1.ADDRESS = '0; b1.WRITEDATA = '0; b1.READ = 0; b1.WRITE = 0; b1.BEGINTRANSFER = 0; b1.LOCK = 0;
        b0.ADDRESS = '0; b0.WRITEDATA = '0; b0.READ = 0; b0.WRITE = 0; b0.BEGINTRANSFER = 0; b0.LOCK = 0;
        test_reset;
        test_write_wait1;
        test_zero_wait;
        test_tx;
        test_lock;
        test_unmapped;
        test_abort;
        test_reset_mid;
        test_same_cycle;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
